execute: RTL and testbench

- Execute (EX) stage of the single-issue MIPS datapath.
- Selects the second ALU operand (register or immediate) and decodes ALUOp/funct into an ALU operation.
- Computes a 32-bit result and registers it, together with a zero flag, on the rising clock edge.
- Sits between decode (register file plus sign-extender) and memory/branch logic; `zero` feeds the branch decision.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/alu_core.sv | 31 +++
 rtl/execute.sv | 92 +++++++++
 tb/tb_execute.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALUOp classes, R-type funct codes and the internal ALU control set.
package mips_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_ADDI  = 3'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_ANDI  = 3'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 3'd5;
  localparam logic [ALUOP_W-1:0] ALUOP_SLTI  = 3'd6;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 3'd7;

  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FUNCT_W-1:0] FN_SLLV = 6'h04;
  localparam logic [FUNCT_W-1:0] FN_SRLV = 6'h06;
  localparam logic [FUNCT_W-1:0] FN_SRAV = 6'h07;
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    CTL_ADD, CTL_SUB, CTL_AND, CTL_OR, CTL_XOR, CTL_NOR, CTL_SLT,
    CTL_SLTU, CTL_SLL, CTL_SRL, CTL_SRA, CTL_LUI, CTL_ZERO
  } alu_ctl_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU; shifts operate on b by shamt, lui places b[15:0] in the upper half.
module alu_core
  import mips_pkg::*;
(
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  input  alu_ctl_e           alu_ctl,
  output logic [WIDTH-1:0]   result
);

  always_comb begin
    result = '0;
    case (alu_ctl)
      CTL_ADD:  result = a + b;
      CTL_SUB:  result = a - b;
      CTL_AND:  result = a & b;
      CTL_OR:   result = a | b;
      CTL_XOR:  result = a ^ b;
      CTL_NOR:  result = ~(a | b);
      CTL_SLT:  result = WIDTH'($signed(a) < $signed(b));
      CTL_SLTU: result = WIDTH'(a < b);
      CTL_SLL:  result = b << shamt;
      CTL_SRL:  result = b >> shamt;
      CTL_SRA:  result = WIDTH'($signed(b) >>> shamt);
      CTL_LUI:  result = WIDTH'(b[15:0]) << 16;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// MIPS EX stage: operand select, ALUOp/funct decode, registered result and zero flag.
module execute
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   AluReadData1,
  input  logic [WIDTH-1:0]   AluReadData2,
  input  logic [WIDTH-1:0]   immediate,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic               ALUSrc,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               zero
);

  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   imm_zext;
  logic [WIDTH-1:0]   core_b;
  logic [SHAMT_W-1:0] core_shamt;
  alu_ctl_e           alu_ctl;
  logic [WIDTH-1:0]   result_d, result_q;
  logic               zero_d, zero_q;

  assign op_b     = ALUSrc ? immediate : AluReadData2;
  assign imm_zext = WIDTH'(immediate[15:0]);

  // Decode; shift forms force b to the rt value and pick fixed or variable shamt.
  always_comb begin
    alu_ctl    = CTL_ZERO;
    core_b     = op_b;
    core_shamt = immediate[10:6];
    case (ALUOp)
      ALUOP_ADD, ALUOP_ADDI: alu_ctl = CTL_ADD;
      ALUOP_SUB:             alu_ctl = CTL_SUB;
      ALUOP_ANDI: begin alu_ctl = CTL_AND; core_b = imm_zext; end
      ALUOP_ORI:  begin alu_ctl = CTL_OR;  core_b = imm_zext; end
      ALUOP_SLTI:            alu_ctl = CTL_SLT;
      ALUOP_LUI:  begin alu_ctl = CTL_LUI; core_b = immediate; end
      ALUOP_RTYPE: begin
        case (funct)
          FN_SLL:  begin alu_ctl = CTL_SLL; core_b = AluReadData2; end
          FN_SRL:  begin alu_ctl = CTL_SRL; core_b = AluReadData2; end
          FN_SRA:  begin alu_ctl = CTL_SRA; core_b = AluReadData2; end
          FN_SLLV: begin
            alu_ctl = CTL_SLL; core_b = AluReadData2; core_shamt = AluReadData1[4:0];
          end
          FN_SRLV: begin
            alu_ctl = CTL_SRL; core_b = AluReadData2; core_shamt = AluReadData1[4:0];
          end
          FN_SRAV: begin
            alu_ctl = CTL_SRA; core_b = AluReadData2; core_shamt = AluReadData1[4:0];
          end
          FN_ADD, FN_ADDU: alu_ctl = CTL_ADD;
          FN_SUB, FN_SUBU: alu_ctl = CTL_SUB;
          FN_AND:  alu_ctl = CTL_AND;
          FN_OR:   alu_ctl = CTL_OR;
          FN_XOR:  alu_ctl = CTL_XOR;
          FN_NOR:  alu_ctl = CTL_NOR;
          FN_SLT:  alu_ctl = CTL_SLT;
          FN_SLTU: alu_ctl = CTL_SLTU;
          default: alu_ctl = CTL_ZERO;
        endcase
      end
      default: alu_ctl = CTL_ZERO;
    endcase
  end

  alu_core u_alu_core (
    .a       (AluReadData1),
    .b       (core_b),
    .shamt   (core_shamt),
    .alu_ctl (alu_ctl),
    .result  (result_d)
  );

  assign zero_d = (result_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign ALUResult = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the EX stage: directed cases plus randomized ops against a reference model.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] AluReadData1, AluReadData2, immediate;
  logic [5:0]  funct;
  logic [2:0]  ALUOp;
  logic        ALUSrc;
  logic [31:0] ALUResult;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  execute dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .AluReadData1 (AluReadData1),
    .AluReadData2 (AluReadData2),
    .immediate    (immediate),
    .funct        (funct),
    .ALUOp        (ALUOp),
    .ALUSrc       (ALUSrc),
    .ALUResult    (ALUResult),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  // Reference: the instruction semantics written out directly.
  function automatic logic [31:0] model(input logic [31:0] a, rt, imm,
                                        input logic [5:0] fn, input logic [2:0] op,
                                        input logic src);
    logic [31:0] b;
    logic signed [31:0] srt;
    int sh, shv;
    b   = src ? imm : rt;
    srt = rt;
    sh  = int'(imm[10:6]);
    shv = int'(a[4:0]);
    case (op)
      3'd0, 3'd3: return a + b;
      3'd1: return a - b;
      3'd4: return a & {16'h0000, imm[15:0]};
      3'd5: return a | {16'h0000, imm[15:0]};
      3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd7: return {imm[15:0], 16'h0000};
      default: begin
        case (fn)
          6'h00: return rt << sh;
          6'h02: return rt >> sh;
          6'h03: return 32'(srt >>> sh);
          6'h04: return rt << shv;
          6'h06: return rt >> shv;
          6'h07: return 32'(srt >>> shv);
          6'h20, 6'h21: return a + b;
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: return (a < b) ? 32'd1 : 32'd0;
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, rt, imm, input logic [5:0] fn,
                       input logic [2:0] op, input logic src);
    @(negedge clk);
    AluReadData1 = a; AluReadData2 = rt; immediate = imm;
    funct = fn; ALUOp = op; ALUSrc = src;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] er, input logic ez);
    n_cmp++;
    assert (ALUResult === er) else begin
      n_err++;
      $error("FAIL %s: ALUResult=%h expected=%h", tag, ALUResult, er);
    end
    n_cmp++;
    assert (zero === ez) else begin
      n_err++;
      $error("FAIL %s_zero: zero=%b expected=%b", tag, zero, ez);
    end
  endtask

  logic [5:0] fn_pool [0:19];
  logic [31:0] ra, rr, ri, exp_r;
  logic [5:0]  rf;
  logic [2:0]  ro;
  logic        rs;

  initial begin
    fn_pool = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h05, 6'h3F, 6'h10};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, 6'($urandom), 3'($urandom), 1'($urandom));
      chk("reset_hold", 32'd0, 1'b1);
    end

    @(negedge clk) rst_n = 1'b1;
    drive(32'd3, 32'd5, 32'h82, 6'h00, 3'd0, 1'b0);
    chk("first_add", 32'd8, 1'b0);
    drive(32'd3, 32'd5, 32'h82, 6'h01, 3'd0, 1'b0); chk("add_fn01", 32'd8, 1'b0);
    drive(32'd3, 32'd5, 32'h82, 6'h04, 3'd0, 1'b0); chk("add_fn04", 32'd8, 1'b0);
    drive(32'd3, 32'd5, 32'h82, 6'h05, 3'd0, 1'b0); chk("add_fn05", 32'd8, 1'b0);

    drive(32'd0, 32'd5, 32'h82, 6'h00, 3'd2, 1'b0); chk("sll", 32'd20, 1'b0);
    drive(32'd3, 32'd5, 32'h82, 6'h04, 3'd2, 1'b0); chk("sllv", 32'd40, 1'b0);
    drive(32'd3, 32'd5, 32'h82, 6'h01, 3'd2, 1'b0); chk("bad_fn01", 32'd0, 1'b1);
    drive(32'd3, 32'd5, 32'h82, 6'h05, 3'd2, 1'b0); chk("bad_fn05", 32'd0, 1'b1);
    drive(32'd0, 32'd5, 32'h82, 6'h00, 3'd2, 1'b1); chk("sll_src1", 32'd20, 1'b0);

    drive(32'd3, 32'd5, 32'h82, 6'h00, 3'd3, 1'b1); chk("addi", 32'd133, 1'b0);
    drive(32'hFFFF_FFFF, 32'd5, 32'd1, 6'h00, 3'd3, 1'b1); chk("addi_wrap", 32'd0, 1'b1);

    drive(32'h1234, 32'h1234, 32'd0, 6'h00, 3'd1, 1'b0); chk("sub_eq", 32'd0, 1'b1);
    drive(32'h1235, 32'h1234, 32'd0, 6'h00, 3'd1, 1'b0); chk("sub_ne", 32'd1, 1'b0);

    drive(32'hFFFF_FFFF, 32'd1, 32'd0, 6'h2A, 3'd2, 1'b0); chk("slt", 32'd1, 1'b0);
    drive(32'hFFFF_FFFF, 32'd1, 32'd0, 6'h2B, 3'd2, 1'b0); chk("sltu", 32'd0, 1'b1);
    drive(32'd0, 32'h8000_0000, 32'h100, 6'h03, 3'd2, 1'b0); chk("sra", 32'hF800_0000, 1'b0);
    drive(32'd0, 32'd0, 32'h0000_ABCD, 6'h00, 3'd7, 1'b0); chk("lui", 32'hABCD_0000, 1'b0);
    drive(32'hFFFF_FFFF, 32'd0, 32'hFFFF_8001, 6'h00, 3'd4, 1'b1); chk("andi_zext", 32'h0000_8001, 1'b0);
    drive(32'd0, 32'd0, 32'hFFFF_8001, 6'h00, 3'd5, 1'b1); chk("ori_zext", 32'h0000_8001, 1'b0);

    drive(32'd3, 32'd5, 32'h82, 6'h00, 3'd0, 1'b0); chk("pre_reset", 32'd8, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 32'd0, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_reset", 32'd8, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom; rr = $urandom; ri = $urandom;
      if (i % 4 == 0) ri = {{16{ri[15]}}, ri[15:0]};
      if (i % 7 == 0) rr = ra;
      rf = fn_pool[$urandom_range(0, 19)];
      ro = 3'($urandom_range(0, 7));
      rs = 1'($urandom);
      exp_r = model(ra, rr, ri, rf, ro, rs);
      drive(ra, rr, ri, rf, ro, rs);
      chk($sformatf("rand%0d_op%0d_fn%h", i, ro, rf), exp_r, exp_r == 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
